// File: rtl/sprf_core_if.sv
// sprf_core_if: wrapper-to-core bus carrying pointer selects, ops, load data and read-back.
interface sprf_core_if #(
    parameter int SPRF_DAT_W = 16,
    parameter int SPRF_TYP_W = 3
);
    logic                  t_cs;
    logic                  ipt_wrp_to_sprf0_r_sel;
    logic                  ipt_wrp_to_sprf1_r_sel;
    logic [SPRF_TYP_W-1:0] ipt_wrp_to_sprf_r0_typ_sel;
    logic [SPRF_TYP_W-1:0] ipt_wrp_to_sprf_r1_typ_sel;
    logic [SPRF_DAT_W-1:0] ipt_wrp_to_sprf_t_dat;
    logic [SPRF_DAT_W-1:0] opt_sprf_to_wrp_dat;
    logic [1:0]            opt_sprf_wrap;
    modport master (
        output t_cs, ipt_wrp_to_sprf0_r_sel, ipt_wrp_to_sprf1_r_sel,
               ipt_wrp_to_sprf_r0_typ_sel, ipt_wrp_to_sprf_r1_typ_sel, ipt_wrp_to_sprf_t_dat,
        input  opt_sprf_to_wrp_dat, opt_sprf_wrap
    );
    modport slave (
        input  t_cs, ipt_wrp_to_sprf0_r_sel, ipt_wrp_to_sprf1_r_sel,
               ipt_wrp_to_sprf_r0_typ_sel, ipt_wrp_to_sprf_r1_typ_sel, ipt_wrp_to_sprf_t_dat,
        output opt_sprf_to_wrp_dat, opt_sprf_wrap
    );
endinterface

// File: rtl/sprf_core.sv
// sprf_core: two wrapping pointer registers with programmable limits, combinational read with op forwarding.
module sprf_core #(
    parameter int                    SPRF_DAT_W = 16,
    parameter int                    SPRF_TYP_W = 3,
    parameter int                    STRIDE     = 4,
    parameter logic [SPRF_DAT_W-1:0] LIM_RST    = '1
) (
    input logic        clk,
    input logic        reset_b,
    sprf_core_if.slave bus
);
    localparam int W = SPRF_DAT_W;
    localparam logic [SPRF_TYP_W-1:0] OP_LOAD  = SPRF_TYP_W'(1);
    localparam logic [SPRF_TYP_W-1:0] OP_INC   = SPRF_TYP_W'(2);
    localparam logic [SPRF_TYP_W-1:0] OP_DEC   = SPRF_TYP_W'(3);
    localparam logic [SPRF_TYP_W-1:0] OP_ADDS  = SPRF_TYP_W'(4);
    localparam logic [SPRF_TYP_W-1:0] OP_CLR   = SPRF_TYP_W'(5);
    localparam logic [SPRF_TYP_W-1:0] OP_LDLIM = SPRF_TYP_W'(6);

    logic [1:0][W-1:0] nxt;
    logic [1:0]        wrap_v;
    logic [1:0]        sel_now;

    assign sel_now = {bus.ipt_wrp_to_sprf1_r_sel, bus.ipt_wrp_to_sprf0_r_sel};

    for (genvar k = 0; k < 2; k++) begin : g_ptr
        logic [W-1:0]          idx_q, idx_d, lim_q, lim_d;
        logic                  wrap_q, wrap_d, sel_q, cmt, add_wr;
        logic [SPRF_TYP_W-1:0] op;
        logic [W:0]            inc_s, add_s;
        assign op     = (k == 0) ? bus.ipt_wrp_to_sprf_r0_typ_sel : bus.ipt_wrp_to_sprf_r1_typ_sel;
        assign cmt    = bus.t_cs & sel_q;
        // Sums kept one bit wider so limit compares and rollover see the true value
        assign inc_s  = {1'b0, idx_q} + (W+1)'(1);
        assign add_s  = {1'b0, idx_q} + (W+1)'(STRIDE);
        assign add_wr = add_s > {1'b0, lim_q};
        always_comb begin
            idx_d  = idx_q;
            lim_d  = lim_q;
            wrap_d = wrap_q;
            if (cmt) begin
                case (op)
                    OP_LOAD: begin
                        idx_d  = bus.ipt_wrp_to_sprf_t_dat;
                        wrap_d = 1'b0;
                    end
                    OP_INC: begin
                        idx_d  = (idx_q == lim_q) ? '0 : inc_s[W-1:0];
                        wrap_d = wrap_q | (idx_q == lim_q) | inc_s[W];
                    end
                    OP_DEC: begin
                        idx_d  = (idx_q == '0) ? lim_q : idx_q - W'(1);
                        wrap_d = wrap_q | (idx_q == '0);
                    end
                    OP_ADDS: begin
                        idx_d  = add_wr ? W'(add_s - ({1'b0, lim_q} + (W+1)'(1))) : add_s[W-1:0];
                        wrap_d = wrap_q | add_wr;
                    end
                    OP_CLR: begin
                        idx_d  = '0;
                        wrap_d = 1'b0;
                    end
                    OP_LDLIM: lim_d = bus.ipt_wrp_to_sprf_t_dat;
                    default: ;
                endcase
            end
        end
        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                idx_q  <= '0;
                lim_q  <= LIM_RST;
                wrap_q <= 1'b0;
                sel_q  <= 1'b0;
            end else if (bus.t_cs) begin
                idx_q  <= idx_d;
                lim_q  <= lim_d;
                wrap_q <= wrap_d;
                sel_q  <= sel_now[k];
            end
        end
        // idx_d already equals idx_q when nothing commits, so reading it forwards only real updates
        assign nxt[k]    = idx_d;
        assign wrap_v[k] = wrap_q;
    end

    assign bus.opt_sprf_wrap       = wrap_v;
    assign bus.opt_sprf_to_wrp_dat = sel_now[0] ? nxt[0] : sel_now[1] ? nxt[1] : '0;
endmodule

// File: tb/tb_sprf_core.sv
// tb_sprf_core: directed per-cycle vectors feed a scoreboard; a negedge monitor checks every read.
module tb_sprf_core;
    localparam logic [2:0] H = 3'd0, L = 3'd1, I = 3'd2, D = 3'd3, A = 3'd4, C = 3'd5, M = 3'd6;

    typedef struct {
        logic [15:0] dat;
        logic [1:0]  wrp;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic reset_b;
    exp_t sb[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   nid = 1;

    sprf_core_if #(.SPRF_DAT_W(16), .SPRF_TYP_W(3)) bus ();

    sprf_core dut (
        .clk    (clk),
        .reset_b(reset_b),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (reset_b && (bus.ipt_wrp_to_sprf0_r_sel || bus.ipt_wrp_to_sprf1_r_sel)) begin
            n_run++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: read with no expected entry, dat=%h", bus.opt_sprf_to_wrp_dat);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.opt_sprf_to_wrp_dat !== e.dat || bus.opt_sprf_wrap !== e.wrp) begin
                    n_fail++;
                    $display("FAIL rd%0d: got dat=%h wrap=%b, expected dat=%h wrap=%b",
                             e.id, bus.opt_sprf_to_wrp_dat, bus.opt_sprf_wrap, e.dat, e.wrp);
                end
            end
        end
    end

    task automatic cyc(input logic s0, input logic s1, input logic [2:0] t0, input logic [2:0] t1,
                       input logic [15:0] d, input logic cs, input logic [15:0] ed, input logic [1:0] ew);
        bus.t_cs                       = cs;
        bus.ipt_wrp_to_sprf0_r_sel     = s0;
        bus.ipt_wrp_to_sprf1_r_sel     = s1;
        bus.ipt_wrp_to_sprf_r0_typ_sel = t0;
        bus.ipt_wrp_to_sprf_r1_typ_sel = t1;
        bus.ipt_wrp_to_sprf_t_dat      = d;
        if (s0 || s1) begin
            sb.push_back('{ed, ew, nid});
            nid++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_b = 1'b0;
        bus.t_cs = 1'b1;
        bus.ipt_wrp_to_sprf0_r_sel = 1'b0;
        bus.ipt_wrp_to_sprf1_r_sel = 1'b0;
        bus.ipt_wrp_to_sprf_r0_typ_sel = H;
        bus.ipt_wrp_to_sprf_r1_typ_sel = H;
        bus.ipt_wrp_to_sprf_t_dat = '0;
        repeat (2) @(posedge clk);
        #1 reset_b = 1'b1;
        // reset state
        cyc(1, 0, H, H, 16'h0, 1, 16'h0000, 2'b00);
        cyc(0, 0, H, H, 16'h0, 1, 16'h0000, 2'b00);
        // LOAD 0x40 then back-to-back INC reads
        cyc(1, 0, H, H, 16'h0,  1, 16'h0000, 2'b00);
        cyc(1, 0, L, H, 16'h40, 1, 16'h0040, 2'b00);
        cyc(1, 0, I, H, 16'h0,  1, 16'h0041, 2'b00);
        cyc(1, 0, I, H, 16'h0,  1, 16'h0042, 2'b00);
        cyc(0, 0, I, H, 16'h0,  1, 16'h0000, 2'b00);
        cyc(1, 0, H, H, 16'h0,  1, 16'h0043, 2'b00);
        cyc(0, 0, H, H, 16'h0,  1, 16'h0000, 2'b00);
        // LDLIM 7, LOAD 6, three ADDS on IDX1
        cyc(0, 1, H, H, 16'h0, 1, 16'h0000, 2'b00);
        cyc(0, 1, H, M, 16'h7, 1, 16'h0000, 2'b00);
        cyc(0, 1, H, L, 16'h6, 1, 16'h0006, 2'b00);
        cyc(0, 1, H, A, 16'h0, 1, 16'h0002, 2'b00);
        cyc(0, 1, H, A, 16'h0, 1, 16'h0006, 2'b10);
        cyc(0, 1, H, A, 16'h0, 1, 16'h0002, 2'b10);
        cyc(0, 1, H, H, 16'h0, 1, 16'h0002, 2'b10);
        cyc(0, 0, H, H, 16'h0, 1, 16'h0000, 2'b10);
        // CLR, DEC from 0 wraps to LIM_RST, CLR clears wrap
        cyc(1, 0, H, H, 16'h0, 1, 16'h0043, 2'b10);
        cyc(1, 0, C, H, 16'h0, 1, 16'h0000, 2'b10);
        cyc(1, 0, D, H, 16'h0, 1, 16'hFFFF, 2'b10);
        cyc(1, 0, C, H, 16'h0, 1, 16'h0000, 2'b11);
        cyc(1, 0, H, H, 16'h0, 1, 16'h0000, 2'b10);
        cyc(0, 0, H, H, 16'h0, 1, 16'h0000, 2'b10);
        // IDX0=5, IDX1=9, both selected with INC on both
        cyc(1, 0, H, H, 16'h0, 1, 16'h0000, 2'b10);
        cyc(0, 1, L, H, 16'h5, 1, 16'h0002, 2'b10);
        cyc(0, 0, H, L, 16'h9, 1, 16'h0000, 2'b10);
        cyc(1, 1, H, H, 16'h0, 1, 16'h0005, 2'b00);
        cyc(0, 0, I, I, 16'h0, 1, 16'h0000, 2'b00);
        cyc(0, 1, H, H, 16'h0, 1, 16'h000A, 2'b00);
        cyc(1, 0, H, H, 16'h0, 1, 16'h0006, 2'b00);
        cyc(0, 0, H, H, 16'h0, 1, 16'h0000, 2'b00);
        // INC at IDX == LIM wraps to 0
        cyc(0, 1, H, H, 16'h0, 1, 16'h000A, 2'b00);
        cyc(0, 1, H, L, 16'h7, 1, 16'h0007, 2'b00);
        cyc(0, 1, H, I, 16'h0, 1, 16'h0000, 2'b00);
        cyc(0, 1, H, H, 16'h0, 1, 16'h0000, 2'b10);
        cyc(0, 0, H, H, 16'h0, 1, 16'h0000, 2'b10);
        // t_cs low freezes a pending INC and suppresses forwarding; sel_q holds
        cyc(1, 0, H, H, 16'h0, 1, 16'h0006, 2'b10);
        cyc(1, 0, I, H, 16'h0, 0, 16'h0006, 2'b10);
        cyc(1, 0, H, H, 16'h0, 1, 16'h0006, 2'b10);
        cyc(0, 0, H, H, 16'h0, 0, 16'h0000, 2'b10);
        cyc(1, 0, I, H, 16'h0, 1, 16'h0007, 2'b10);
        cyc(0, 0, H, H, 16'h0, 1, 16'h0000, 2'b10);
        // reset pulse while an INC is pending discards it
        cyc(1, 0, H, H, 16'h0, 1, 16'h0007, 2'b10);
        bus.ipt_wrp_to_sprf0_r_sel = 1'b0;
        bus.ipt_wrp_to_sprf_r0_typ_sel = I;
        #1 reset_b = 1'b0;
        #1 reset_b = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 0, H, H, 16'h0, 1, 16'h0000, 2'b00);
        cyc(0, 1, H, H, 16'h0, 1, 16'h0000, 2'b00);
        cyc(0, 0, H, H, 16'h0, 1, 16'h0000, 2'b00);
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
